// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial add controller.
// Holds the FSM state encoding and the nibble width.
package nibble_add_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Producer/consumer handshake bundle for nibble_serial_add_ctrl.
// The sub signal exists only when SUB_MODE_EN is defined.
interface nibble_serial_add_ctrl_if
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SUB_MODE_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  // master drives operations in and accepts results; slave is the controller
  modport master (
`ifdef SUB_MODE_EN
    output sub,
`endif
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
`ifdef SUB_MODE_EN
    input  sub,
`endif
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, sum
  );

endinterface

// File: rtl/nibble_serial_add_ctrl_nibble_adder.sv
// Combinational 4-bit ripple-carry adder made of full-adder cells.
// Shared by every nibble step of the serial controller.
module nibble_adder
  import nibble_add_pkg::*;
(
  input  logic [NIB_W-1:0] x,
  input  logic [NIB_W-1:0] y,
  input  logic             cin,
  output logic [NIB_W-1:0] sum,
  output logic             cout
);

  logic [NIB_W:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < NIB_W; i++) begin : g_fa
    assign sum[i]     = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign cout = carry[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands over WIDTH/4 cycles with a single nibble adder, LSB nibble first.
// Define SUB_MODE_EN to add the sub input (a - b via inverted b and carry-in of 1).
module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  nibble_serial_add_ctrl_if.slave  bus,
  output logic                     busy
);

  localparam int NIBBLES = WIDTH / NIB_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  if ((WIDTH % NIB_W) != 0 || WIDTH < 8) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 8");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH:0]   sum_q, sum_d;

  logic [NIB_W-1:0] nib_x, nib_y, nib_s;
  logic             nib_co;

  // b_q already holds ~b when subtracting, so the adder never sees the mode
  assign nib_x = a_q[idx_q*NIB_W +: NIB_W];
  assign nib_y = b_q[idx_q*NIB_W +: NIB_W];

  nibble_adder u_nibble_adder (
    .x    (nib_x),
    .y    (nib_y),
    .cin  (carry_q),
    .sum  (nib_s),
    .cout (nib_co)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          idx_d   = '0;
          state_d = RUN;
`ifdef SUB_MODE_EN
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.sub;
`else
          b_d     = bus.b;
          carry_d = 1'b0;
`endif
        end
      end

      RUN: begin
        sum_d[idx_q*NIB_W +: NIB_W] = nib_s;
        carry_d = nib_co;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          sum_d[WIDTH] = nib_co;
          state_d      = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sum       = sum_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed self-checking bench for nibble_serial_add_ctrl at WIDTH=16 and WIDTH=32.
// Subtraction vectors run only when SUB_MODE_EN is defined.
module tb_nibble_serial_add_ctrl;

  logic clk;
  logic rst;
  logic busy16;
  logic busy32;

  int compare_count;
  int fail_count;

  nibble_serial_add_ctrl_if #(.WIDTH(16)) if16 ();
  nibble_serial_add_ctrl_if #(.WIDTH(32)) if32 ();

  nibble_serial_add_ctrl #(.WIDTH(16)) dut16 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if16.slave),
    .busy (busy16)
  );

  nibble_serial_add_ctrl #(.WIDTH(32)) dut32 (
    .clk  (clk),
    .rst  (rst),
    .bus  (if32.slave),
    .busy (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation at a negedge and releases in_valid after the accept edge
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic s);
    @(negedge clk);
    if16.in_valid = 1'b1;
    if16.a        = a;
    if16.b        = b;
`ifdef SUB_MODE_EN
    if16.sub      = s;
`else
    if (s) $display("[TB] sub ignored without SUB_MODE_EN");
`endif
    @(posedge clk);
    @(negedge clk);
    if16.in_valid = 1'b0;
  endtask

  // Counts rising edges after the accept edge until out_valid is seen; -1 on timeout
  task automatic waitValid16(output int edges);
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (if16.out_valid) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic waitValid32(output int edges);
    edges = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (if32.out_valid) begin
        edges = n;
        break;
      end
    end
  endtask

  // Full operation with out_ready held high: latency, result and return to IDLE
  task automatic runOp16(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic s, input logic [16:0] exp_sum);
    int edges;
    applyStimulus(a, b, s);
    waitValid16(edges);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd4);
    checkOutput({tag, "_sum"}, 64'(if16.sum), 64'(exp_sum));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {62'd0, if16.out_valid, if16.in_ready}, 64'b01);
  endtask

  task automatic runOp32(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [32:0] exp_sum);
    int edges;
    @(negedge clk);
    if32.in_valid = 1'b1;
    if32.a        = a;
    if32.b        = b;
    @(posedge clk);
    @(negedge clk);
    if32.in_valid = 1'b0;
    waitValid32(edges);
    checkOutput({tag, "_latency"}, 64'(edges), 64'd8);
    checkOutput({tag, "_sum"}, 64'(if32.sum), 64'(exp_sum));
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_idle"}, {62'd0, if32.out_valid, if32.in_ready}, 64'b01);
  endtask

  initial begin
    int   edges;
    logic saw_valid;

    compare_count = 0;
    fail_count    = 0;
    rst           = 1'b1;
    if16.in_valid  = 1'b0;
    if16.a         = '0;
    if16.b         = '0;
    if16.out_ready = 1'b1;
    if32.in_valid  = 1'b0;
    if32.a         = '0;
    if32.b         = '0;
    if32.out_ready = 1'b1;
`ifdef SUB_MODE_EN
    if16.sub = 1'b0;
    if32.sub = 1'b0;
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_in_ready", 64'(if16.in_ready), 64'd0);
    checkOutput("reset_out_valid", 64'(if16.out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy16), 64'd0);
    checkOutput("reset_sum", 64'(if16.sum), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(if16.in_ready), 64'd1);

    // Basic additions, including full carry ripple across every nibble
    runOp16("add_1234_4321", 16'h1234, 16'h4321, 1'b0, 17'h05555);
    runOp16("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 17'h10000);
    runOp16("add_8000_8000", 16'h8000, 16'h8000, 1'b0, 17'h10000);
    runOp16("add_ffff_ffff", 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
    runOp16("add_zero", 16'h0000, 16'h0000, 1'b0, 17'h00000);

    // Backpressure: result must hold while out_ready is low
    if16.out_ready = 1'b0;
    applyStimulus(16'h0F0F, 16'h0101, 1'b0);
    waitValid16(edges);
    checkOutput("bp_latency", 64'(edges), 64'd4);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      checkOutput("bp_hold", {if16.out_valid, if16.in_ready, busy16, if16.sum},
                  {1'b1, 1'b0, 1'b1, 17'h01010});
    end
    if16.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_release", {62'd0, if16.out_valid, if16.in_ready}, 64'b01);
    runOp16("bp_next", 16'h00FF, 16'h0001, 1'b0, 17'h00100);

    // In-flight in_valid is ignored until the controller returns to IDLE
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    if16.in_valid = 1'b1;
    if16.a        = 16'hFFFF;
    if16.b        = 16'hFFFF;
    checkOutput("inflight_in_ready", 64'(if16.in_ready), 64'd0);
    waitValid16(edges);
    checkOutput("inflight_latency", 64'(edges), 64'd4);
    checkOutput("inflight_sum", 64'(if16.sum), 64'h03333);
    @(posedge clk);
    @(negedge clk);
    checkOutput("inflight_idle", {62'd0, if16.out_valid, if16.in_ready}, 64'b01);
    @(posedge clk);
    @(negedge clk);
    if16.in_valid = 1'b0;
    checkOutput("second_accepted", 64'(busy16), 64'd1);
    waitValid16(edges);
    checkOutput("second_latency", 64'(edges), 64'd4);
    checkOutput("second_sum", 64'(if16.sum), 64'h1FFFE);
    @(posedge clk);
    @(negedge clk);

    // Reset during the second RUN cycle aborts the operation
    applyStimulus(16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_state", {61'd0, busy16, if16.out_valid, if16.in_ready}, 64'b000);
    rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (if16.out_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_valid", 64'(saw_valid), 64'd0);
    checkOutput("abort_in_ready", 64'(if16.in_ready), 64'd1);
    runOp16("after_abort", 16'hABCD, 16'h1111, 1'b0, 17'h0BCDE);

`ifdef SUB_MODE_EN
    runOp16("sub_5_3", 16'h0005, 16'h0003, 1'b1, 17'h10002);
    runOp16("sub_3_5", 16'h0003, 16'h0005, 1'b1, 17'h0FFFE);
    runOp16("sub_7_7", 16'h0007, 16'h0007, 1'b1, 17'h10000);
`endif

    runOp32("w32_ffffffff_1", 32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000);
    runOp32("w32_mixed", 32'h1234_5678, 32'h1111_1111, 33'h0_2345_6789);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
